// File: rtl/ext_unit_pipe.sv
// Registered immediate/data extender with a valid/ready handshake and a
// 2-entry skid buffer; entry0 is the head presented on out_*.
module ext_unit_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [1:0]       occupancy
);

  localparam int H = IN_W / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             in_ready_q;
  logic [OUT_W-1:0] e0_data, e1_data;
  logic             e0_err, e1_err;

  logic             accept, pop;
  logic             load_e0, e0_from_in, load_e1;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] new_data;
  logic             new_err;

  assign accept    = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = e0_data;
  assign out_err   = e0_err;

  assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

  always_comb begin
    new_data = '0;
    new_err  = 1'b0;
    case (in_mode)
      3'b000: new_data = {{(OUT_W-IN_W){1'b0}}, in_data};
      3'b001: new_data = sext;
      3'b010: new_data = {in_data, {(OUT_W-IN_W){1'b0}}};
      3'b011: new_data = sext << 2;
      3'b100: new_data = {{(OUT_W-H){in_data[H-1]}}, in_data[H-1:0]};
      3'b101: new_data = {{(OUT_W-H){1'b0}}, in_data[H-1:0]};
      default: begin
        new_data = '0;
        new_err  = 1'b1;
      end
    endcase
  end

  // Occupancy FSM also steers which buffer slot captures data on each edge.
  always_comb begin
    state_d    = state_q;
    load_e0    = 1'b0;
    e0_from_in = 1'b0;
    load_e1    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          load_e0    = 1'b1;
          e0_from_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = TWO;
          load_e1 = 1'b1;
        end else if (accept && pop) begin
          load_e0    = 1'b1;
          e0_from_in = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          load_e0 = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is registered from the next state so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_data <= '0;
      e0_err  <= 1'b0;
      e1_data <= '0;
      e1_err  <= 1'b0;
    end else begin
      if (load_e0) begin
        e0_data <= e0_from_in ? new_data : e1_data;
        e0_err  <= e0_from_in ? new_err  : e1_err;
      end
      if (load_e1) begin
        e1_data <= new_data;
        e1_err  <= new_err;
      end
    end
  end

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed self-checking bench for ext_unit_pipe with hand-computed vectors.
module tb_ext_unit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  ext_unit_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one entry into an empty unit, check it one cycle later, then let it drain.
  task automatic applyStimulus(input string tag, input logic [15:0] d, input logic [2:0] m,
                               input logic [31:0] exp_data, input logic exp_err);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    step();
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_data", out_data, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);

    applyStimulus("sext", 16'h8001, 3'b001, 32'hFFFF8001, 1'b0);
    applyStimulus("zext", 16'h8001, 3'b000, 32'h00008001, 1'b0);
    applyStimulus("upper", 16'h1234, 3'b010, 32'h12340000, 1'b0);
    applyStimulus("br_neg", 16'hFFFF, 3'b011, 32'hFFFFFFFC, 1'b0);
    applyStimulus("br_pos", 16'h0004, 3'b011, 32'h00000010, 1'b0);
    applyStimulus("half_s", 16'h0080, 3'b100, 32'hFFFFFF80, 1'b0);
    applyStimulus("half_z", 16'h0080, 3'b101, 32'h00000080, 1'b0);
    applyStimulus("half_s_pos", 16'hFF7F, 3'b100, 32'h0000007F, 1'b0);
    applyStimulus("rsv110", 16'h0080, 3'b110, 32'h00000000, 1'b1);
    chk("hold_valid", 32'(out_valid), 32'd0);
    chk("hold_err", 32'(out_err), 32'd1);
    applyStimulus("rsv111", 16'hABCD, 3'b111, 32'h00000000, 1'b1);
    applyStimulus("zext_clr", 16'h00FF, 3'b000, 32'h000000FF, 1'b0);
    chk("hold_data", out_data, 32'h000000FF);

    // Backpressure: fill both slots, third push must be held off.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 3'b000;
    in_data   = 16'h0001;
    step();
    chk("bp_occ1", 32'(occupancy), 32'd1);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_data = 16'h0002;
    step();
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_head1", out_data, 32'h00000001);
    in_data = 16'h0003;
    step();
    chk("bp_ign_occ", 32'(occupancy), 32'd2);
    chk("bp_ign_head", out_data, 32'h00000001);
    out_ready = 1'b1;
    step();
    chk("bp_head2", out_data, 32'h00000002);
    chk("bp_occ_after_pop", 32'(occupancy), 32'd1);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_head3", out_data, 32'h00000003);
    chk("bp_occ3", 32'(occupancy), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_drain_occ", 32'(occupancy), 32'd0);

    // Streaming at full rate.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'(16'h0010 + i);
      step();
      chk($sformatf("st_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("st_occ%0d", i), 32'(occupancy), 32'd1);
      chk($sformatf("st_data%0d", i), out_data, 32'(32'h10 + i));
    end
    in_valid = 1'b0;
    step();
    chk("st_end", 32'(out_valid), 32'd0);

    // Reset while full discards everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00AA;
    step();
    in_data = 16'h00BB;
    step();
    chk("rf_occ_full", 32'(occupancy), 32'd2);
    rst     = 1'b1;
    in_data = 16'h00CC;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_occ", 32'(occupancy), 32'd0);
    chk("rf_ready", 32'(in_ready), 32'd1);
    chk("rf_data", out_data, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rf_nothing%0d", i), 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
Parametrised, pipelined immediate/data extension unit. It is the registered successor to the combinational 16→32 extender. It supports six extension modes (zero, sign, upper-placement, branch-offset, half-field sign/zero) behind a valid/ready handshake with a 2-entry skid buffer. It sits between ID and the ID/EX register, and is reusable on the MEM load-data path.

Parameters:
IN_W, 16, input field width; must be even and ≥4.
OUT_W, 32, output width; must be ≥ IN_W+2.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream presents a request.
in_ready  out  1  unit can accept; registered, high when fewer than 2 entries are held.
in_data  in  IN_W  field to extend.
in_mode  in  3  extension mode, see Behaviour.
out_valid  out  1  head entry valid.
out_ready  in  1  downstream accepts the head entry.
out_data  out  OUT_W  extended result of the head entry.
out_err  out  1  head entry used a reserved mode.
occupancy  out  2  entries held (0..2).

Behaviour:
- Reset (rst high at a clk edge) sets out_valid=0, out_data=0, out_err=0, occupancy=0, and in_ready=1 on the next cycle. Reset wins over any simultaneous handshake. In-flight entries are discarded.
- Accept condition: in_valid && in_ready at a clk edge. Pop condition: out_valid && out_ready at a clk edge.
- Result is computed combinationally from in_data/in_mode and stored on accept. Latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N if the buffer was empty.
- Modes. Let H = IN_W/2 and s = in_data[IN_W-1].
  - 000 zero-extend: {0…, in_data}.
  - 001 sign-extend: {s replicated (OUT_W-IN_W), in_data}.
  - 010 upper-place: in_data << (OUT_W-IN_W), low bits 0 (LUI for 16/32).
  - 011 branch offset: sign-extend, then shift left 2, truncated to OUT_W.
  - 100 sign-extend the low H bits, using in_data[H-1] as the sign.
  - 101 zero-extend the low H bits.
  - 110/111 reserved: out_data=0, out_err=1.
  - out_err=0 for all defined modes.
- Storage: entry0 is the head and drives out_*; entry1 is the skid slot. FIFO order is preserved.
- State machine (occupancy):
  - EMPTY(0):
    - accept → ONE.
    - A pop cannot occur in EMPTY.
  - ONE(1):
    - accept, no pop → TWO (new entry goes to entry1).
    - pop, no accept → EMPTY.
    - accept and pop together → ONE (new entry goes to entry0).
  - TWO(2):
    - in_ready=0, so no accept occurs.
    - pop → ONE (entry1 moves to entry0).
- in_ready = (occupancy != 2), driven from a register. No combinational path runs from out_ready to in_ready.
- out_valid = (occupancy != 0). out_data/out_err hold stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_data and out_err hold their last values. They are forced to 0 only by reset.
- Throughput: 1 entry/cycle when out_ready is held high.
- in_valid=1 while in_ready=0 is ignored; the upstream must hold its request.

Test Plan:
1. Reset, then in_data=16'h8001: mode 001 → out_data=32'hFFFF8001; mode 000 → 32'h00008001, out_err=0, each 1 cycle after accept, out_ready=1.
2. Mode 010, in_data=16'h1234 → 32'h12340000. Mode 011, in_data=16'hFFFF → 32'hFFFFFFFC. Mode 011, in_data=16'h0004 → 32'h00000010.
3. Mode 100, in_data=16'h0080 → 32'hFFFFFF80. Mode 101, same input → 32'h00000080. Mode 110 → out_data=0, out_err=1.
4. Backpressure: out_ready=0, push 16'h0001 then 16'h0002 (mode 000).
   - Required: occupancy=2 and in_ready=0. A third push of 16'h0003 is ignored.
   - Raise out_ready: outputs 1, 2, then 3 after it is re-accepted, in order, with no loss or duplication.
5. Streaming: in_valid=1 and out_ready=1 for 8 cycles with incrementing data → out_valid=1 from cycle 2 onward, occupancy stays 1, one result per cycle.
6. Assert rst while occupancy=2 and in_valid=1 → next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0; the pending entries never appear.
